// File: rtl/ntsc_zbt_reader.sv
// Display-side reader for the NTSC frame buffer in ZBT RAM: issues one word fetch
// per four pixels, four clocks ahead of use, and unpacks it to one luma byte per clock.
module ntsc_zbt_reader #(
    parameter int H_TOTAL  = 1344,
    parameter int V_TOTAL  = 806,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        bob,
    input  logic [35:0] vram_read_data,
    output logic [18:0] vram_addr,
    output logic        vram_re,
    output logic [7:0]  vram_pixel
);

    logic [18:0] addr_q, addr_d;
    logic        re_q, re_d;
    logic [1:0]  tag_q, tag_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  pixel_q, pixel_d;

    logic [11:0] xf_sum, xf;
    logic [10:0] vf_sum, vf;
    logic        fetch;
    logic [7:0]  byte_sel;
    logic        unused_tag_bits;

    // Parity bits of the ZBT word are not part of the luma data.
    assign unused_tag_bits = ^vram_read_data[35:32];

    // Fetch target is four pixels ahead, wrapping into the next line and frame.
    always_comb begin
        xf_sum = {1'b0, hcount} + 12'd4;
        vf_sum = {1'b0, vcount} + 11'd1;
        xf     = xf_sum;
        vf     = {1'b0, vcount};
        if (xf_sum >= 12'(H_TOTAL)) begin
            xf = xf_sum - 12'(H_TOTAL);
            vf = (vf_sum == 11'(V_TOTAL)) ? 11'd0 : vf_sum;
        end
        fetch = (xf[1:0] == 2'b00) && (xf < 12'(H_ACTIVE)) && (vf < 11'(V_ACTIVE));
    end

    always_comb begin
        addr_d = addr_q;
        re_d   = fetch;
        if (fetch) begin
            addr_d = {1'b0, vf[9:1], (bob ? 1'b0 : vf[0]), xf[9:2]};
        end
        // Tag emerges in the cycle the read data is on the bus.
        tag_d  = {tag_q[0], re_q};
        word_d = tag_q[1] ? vram_read_data[31:0] : word_q;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (hcount[1:0])
            2'd0: byte_sel = word_q[31:24];
            2'd1: byte_sel = word_q[23:16];
            2'd2: byte_sel = word_q[15:8];
            2'd3: byte_sel = word_q[7:0];
            default: byte_sel = 8'h00;
        endcase
        pixel_d = 8'h00;
        if ((hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE))) begin
            pixel_d = byte_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            re_q    <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
            pixel_q <= '0;
        end else begin
            addr_q  <= addr_d;
            re_q    <= re_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
            pixel_q <= pixel_d;
        end
    end

    assign vram_addr  = addr_q;
    assign vram_re    = re_q;
    assign vram_pixel = pixel_q;

endmodule

// File: tb/tb_ntsc_zbt_reader.sv
// Directed bench for ntsc_zbt_reader: address mapping, unpack order, reset,
// frame wrap, blanking and field alternation.
module tb_ntsc_zbt_reader;

    logic        clk;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        bob;
    logic [35:0] vram_read_data;
    logic [18:0] vram_addr;
    logic        vram_re;
    logic [7:0]  vram_pixel;

    int checks = 0;
    int errors = 0;

    ntsc_zbt_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hcount         (hcount),
        .vcount         (vcount),
        .bob            (bob),
        .vram_read_data (vram_read_data),
        .vram_addr      (vram_addr),
        .vram_re        (vram_re),
        .vram_pixel     (vram_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; afterwards outputs reflect the previous position and the
    // display counters have advanced to the current one.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (hcount == 11'd1343) begin
            hcount = 11'd0;
            vcount = (vcount == 10'd805) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, hcount, vcount);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        hcount         = 11'd0;
        vcount         = 10'd0;
        bob            = 1'b0;
        vram_read_data = 36'h0;
        #3;
        chk("por_addr",  32'(vram_addr), 32'd0);
        chk("por_re",    32'(vram_re), 32'd0);
        chk("por_pixel", 32'(vram_pixel), 32'd0);
        cyc();
        reset_n = 1'b1;

        // Address mapping and unpack order around the hcount=96 fetch.
        hcount = 11'd96; vcount = 10'd161; bob = 1'b0;
        cyc();                                   // h=97
        chk("map_re",   32'(vram_re), 32'd1);
        chk("map_addr", 32'(vram_addr), 32'd41241);
        cyc();                                   // h=98
        chk("map_re_off", 32'(vram_re), 32'd0);
        cyc();                                   // h=99: data on the bus
        vram_read_data = 36'h0_11223344;
        cyc();                                   // h=100
        vram_read_data = 36'hF_DEADBEEF;
        cyc();  chk("unpack_b0", 32'(vram_pixel), 32'h11);   // h=101
        chk("next_fetch_re", 32'(vram_re), 32'd1);
        cyc();  chk("unpack_b1", 32'(vram_pixel), 32'h22);
        cyc();  chk("unpack_b2", 32'(vram_pixel), 32'h33);
        cyc();  chk("unpack_b3", 32'(vram_pixel), 32'h44);   // h=104
        cyc();  chk("next_word", 32'(vram_pixel), 32'hDE);   // h=105

        hcount = 11'd96; vcount = 10'd161; bob = 1'b1;
        cyc();
        chk("bob_addr", 32'(vram_addr), 32'd40985);
        bob = 1'b0;

        // Reset mid-line, then recovery.
        hcount = 11'd48; vcount = 10'd100;
        cyc(); cyc();                            // h=50
        reset_n = 1'b0;
        #1;
        chk("rst_pixel", 32'(vram_pixel), 32'd0);
        chk("rst_re",    32'(vram_re), 32'd0);
        chk("rst_addr",  32'(vram_addr), 32'd0);
        vram_read_data = 36'h0_55667788;
        cyc();                                   // h=51
        reset_n = 1'b1;
        cyc();  chk("rel_re_52", 32'(vram_re), 32'd0);
        chk("rel_pix_52", 32'(vram_pixel), 32'd0);
        cyc();  chk("rel_re_53", 32'(vram_re), 32'd1);
        chk("rel_addr", 32'(vram_addr), 32'd25614);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rel_pix_zero", 32'(vram_pixel), 32'd0);
        end
        cyc();  chk("rel_first_word", 32'(vram_pixel), 32'h55);  // h=57
        cyc();  chk("rel_second_byte", 32'(vram_pixel), 32'h66);

        // Horizontal blanking with non-zero bus data.
        hcount = 11'd1020; vcount = 10'd10;
        vram_read_data = 36'hF_FFFFFFFF;
        while (hcount != 11'd1340) begin
            cyc();
            if (hcount >= 11'd1025) begin
                chk("hblank_re",    32'(vram_re), 32'd0);
                chk("hblank_pixel", 32'(vram_pixel), 32'd0);
            end
        end

        // Vertical blanking: a whole line.
        hcount = 11'd0; vcount = 10'd790;
        for (int i = 0; i < 1344; i++) begin
            cyc();
            chk("vblank_re",    32'(vram_re), 32'd0);
            chk("vblank_pixel", 32'(vram_pixel), 32'd0);
        end

        // Frame wrap.
        hcount = 11'd1340; vcount = 10'd805;
        vram_read_data = 36'h0;
        cyc();                                   // h=1341
        chk("wrap_re",   32'(vram_re), 32'd1);
        chk("wrap_addr", 32'(vram_addr), 32'd0);
        cyc();                                   // h=1342
        cyc();                                   // h=1343
        vram_read_data = 36'h0_A0B1C2D3;
        cyc();                                   // h=0, v=0
        vram_read_data = 36'h0_12345678;
        chk("wrap_pix_blank", 32'(vram_pixel), 32'd0);
        cyc();                                   // h=1, v=0
        chk("wrap_pixel", 32'(vram_pixel), 32'hA0);
        cyc();
        chk("wrap_pixel_b1", 32'(vram_pixel), 32'hB1);

        // Field alternation.
        hcount = 11'd0; vcount = 10'd10;
        cyc();
        chk("field0_addr", 32'(vram_addr), 32'd2561);
        hcount = 11'd0; vcount = 10'd11;
        cyc();
        chk("field1_addr", 32'(vram_addr), 32'd2817);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
